// File: rtl/control_sequencer_pkg.sv
// Shared types and constants for the control sequencer: state codes, opcode
// fields, ALU functions, register indices and the registered strobe bundle.
package ctl_pkg;

    // Sequencer states, kept as plain constants for legacy tool compatibility.
    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE = 4'd0;
    localparam state_t ST_F_D  = 4'd1;
    localparam state_t ST_F_L  = 4'd2;
    localparam state_t ST_M_D  = 4'd3;
    localparam state_t ST_M_L  = 4'd4;
    localparam state_t ST_A_D  = 4'd5;
    localparam state_t ST_A_L  = 4'd6;
    localparam state_t ST_W_D  = 4'd7;
    localparam state_t ST_W_L  = 4'd8;
    localparam state_t ST_I_D  = 4'd9;
    localparam state_t ST_I_L  = 4'd10;
    localparam state_t ST_HALT = 4'd11;

    // Opcode class in ir[7:6].
    localparam logic [1:0] CLS_MOV = 2'b00;
    localparam logic [1:0] CLS_ALU = 2'b01;
    localparam logic [1:0] CLS_LDI = 2'b10;
    localparam logic [1:0] CLS_SYS = 2'b11;

    localparam logic [7:0] OP_HALT = 8'hFF;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_XOR = 2'd3;

    localparam logic [1:0] REG_A = 2'd0;
    localparam logic [1:0] REG_B = 2'd1;
    localparam logic [1:0] REG_C = 2'd2;
    localparam logic [1:0] REG_D = 2'd3;

    // Every strobe the sequencer drives, registered as one bundle.
    typedef struct packed {
        logic       mem_rd;
        logic       pc_inc;
        logic       ir_load;
        logic [3:0] assert_lhs;
        logic [3:0] assert_rhs;
        logic [3:0] assert_bus;
        logic [3:0] load_bus;
        logic [1:0] alu_op;
        logic       alu_latch;
        logic       alu_assert_bus;
        logic       halted;
    } strobe_t;

    // Register index to one-hot select.
    function automatic logic [3:0] reg_onehot(input logic [1:0] idx);
        reg_onehot = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Memory, register-file and ALU control signals of the sequencer.
// master: the sequencer side; slave: the datapath/memory side.
interface control_sequencer_if;

    logic       run;
    logic [7:0] bus_in;
    logic       mem_ready;
    logic       mem_rd;
    logic       pc_inc;
    logic       ir_load;
    logic [3:0] assert_lhs;
    logic [3:0] assert_rhs;
    logic [3:0] assert_bus;
    logic [3:0] load_bus;
    logic [1:0] alu_op;
    logic       alu_latch;
    logic       alu_assert_bus;
    logic       halted;

    modport master (
        input  run, bus_in, mem_ready,
        output mem_rd, pc_inc, ir_load, assert_lhs, assert_rhs, assert_bus, load_bus,
               alu_op, alu_latch, alu_assert_bus, halted
    );

    modport slave (
        output run, bus_in, mem_ready,
        input  mem_rd, pc_inc, ir_load, assert_lhs, assert_rhs, assert_bus, load_bus,
               alu_op, alu_latch, alu_assert_bus, halted
    );

endinterface

// File: rtl/control_sequencer_decode.sv
// Combinational strobe decode: maps a state and the instruction register to
// the strobe bundle that must be visible while that state is current.
module ctl_decode
    import ctl_pkg::*;
(
    input  state_t     state_i,
    input  logic [7:0] ir_i,
    output strobe_t    strobe_o
);

    // ir[3:2] is MOV destination / ALU lhs; ir[1:0] is MOV source / ALU rhs / LDI dest.
    logic [3:0] sel_hi;
    logic [3:0] sel_lo;

    assign sel_hi = reg_onehot(ir_i[3:2]);
    assign sel_lo = reg_onehot(ir_i[1:0]);

    // Per-state strobe table; anything not listed stays low.
    always_comb begin
        strobe_o = '0;
        case (state_i)
            ST_F_D: begin
                strobe_o.mem_rd = 1'b1;
            end
            ST_F_L: begin
                strobe_o.mem_rd  = 1'b1;
                strobe_o.ir_load = 1'b1;
                strobe_o.pc_inc  = 1'b1;
            end
            ST_M_D: begin
                strobe_o.assert_bus = sel_lo;
            end
            ST_M_L: begin
                strobe_o.assert_bus = sel_lo;
                strobe_o.load_bus   = sel_hi;
            end
            ST_A_D: begin
                strobe_o.assert_lhs = sel_hi;
                strobe_o.assert_rhs = sel_lo;
                strobe_o.alu_op     = ir_i[5:4];
            end
            ST_A_L: begin
                strobe_o.assert_lhs = sel_hi;
                strobe_o.assert_rhs = sel_lo;
                strobe_o.alu_op     = ir_i[5:4];
                strobe_o.alu_latch  = 1'b1;
            end
            ST_W_D: begin
                strobe_o.alu_assert_bus = 1'b1;
            end
            ST_W_L: begin
                strobe_o.alu_assert_bus = 1'b1;
                strobe_o.load_bus       = sel_hi;
            end
            ST_I_D: begin
                strobe_o.mem_rd = 1'b1;
            end
            ST_I_L: begin
                strobe_o.mem_rd   = 1'b1;
                strobe_o.pc_inc   = 1'b1;
                strobe_o.load_bus = sel_lo;
            end
            ST_HALT: begin
                strobe_o.halted = 1'b1;
            end
            default: begin
                strobe_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Micro-sequencer: fetches opcodes, splits every register transfer into a
// drive cycle and a latch cycle, and drives registered, glitch-free strobes.
module control_sequencer
    import ctl_pkg::*;
(
    input logic                 clk,
    input logic                 rst_n,
    control_sequencer_if.master bus
);

    state_t     state_q, state_d;
    logic [7:0] ir_q, ir_d;
    strobe_t    strobe_q, strobe_d;

    // Next state; the opcode is taken from the bus at the end of F_L, so
    // dispatch decodes bus_in directly rather than the stale ir.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.run) state_d = ST_F_D;
            end
            ST_F_D: begin
                if (bus.mem_ready) state_d = ST_F_L;
            end
            ST_F_L: begin
                ir_d = bus.bus_in;
                case (bus.bus_in[7:6])
                    CLS_MOV: state_d = ST_M_D;
                    CLS_ALU: state_d = ST_A_D;
                    CLS_LDI: state_d = ST_I_D;
                    default: state_d = (bus.bus_in == OP_HALT) ? ST_HALT : ST_F_D;
                endcase
            end
            ST_M_D:  state_d = ST_M_L;
            ST_M_L:  state_d = ST_F_D;
            ST_A_D:  state_d = ST_A_L;
            ST_A_L:  state_d = ST_W_D;
            ST_W_D:  state_d = ST_W_L;
            ST_W_L:  state_d = ST_F_D;
            ST_I_D: begin
                if (bus.mem_ready) state_d = ST_I_L;
            end
            ST_I_L:  state_d = ST_F_D;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes are decoded from the state being entered and then registered.
    ctl_decode u_decode (
        .state_i  (state_d),
        .ir_i     (ir_d),
        .strobe_o (strobe_d)
    );

    // State, instruction and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ir_q     <= 8'h00;
            strobe_q <= '0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            strobe_q <= strobe_d;
        end
    end

    assign bus.mem_rd         = strobe_q.mem_rd;
    assign bus.pc_inc         = strobe_q.pc_inc;
    assign bus.ir_load        = strobe_q.ir_load;
    assign bus.assert_lhs     = strobe_q.assert_lhs;
    assign bus.assert_rhs     = strobe_q.assert_rhs;
    assign bus.assert_bus     = strobe_q.assert_bus;
    assign bus.load_bus       = strobe_q.load_bus;
    assign bus.alu_op         = strobe_q.alu_op;
    assign bus.alu_latch      = strobe_q.alu_latch;
    assign bus.alu_assert_bus = strobe_q.alu_assert_bus;
    assign bus.halted         = strobe_q.halted;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: an instruction-level model expands each fetched
// opcode into its list of expected output cycles; the DUT is compared against
// it every cycle, bus-safety invariants are checked, and directed sequences pin
// literal values.
module tb_control_sequencer;
    import ctl_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    control_sequencer_if sif ();

    control_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif)
    );

    always #5 clk = ~clk;

    // One expected output cycle; gate: repeats while mem_ready is low;
    // dispatch: the opcode on the bus at the end of this cycle is executed.
    typedef struct packed {
        logic    gate;
        logic    dispatch;
        strobe_t o;
    } step_t;

    step_t      q[$];
    logic       m_idle;
    logic       m_halt;
    strobe_t    m_exp;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] prog[64];
    int         pc = 0;
    logic       inc_prev = 1'b0;
    int         pc_inc_cnt = 0;
    logic [5:0] prev_drv = '0;
    strobe_t    e;

    function automatic strobe_t dut_vec();
        strobe_t v;
        v.mem_rd         = sif.mem_rd;
        v.pc_inc         = sif.pc_inc;
        v.ir_load        = sif.ir_load;
        v.assert_lhs     = sif.assert_lhs;
        v.assert_rhs     = sif.assert_rhs;
        v.assert_bus     = sif.assert_bus;
        v.load_bus       = sif.load_bus;
        v.alu_op         = sif.alu_op;
        v.alu_latch      = sif.alu_latch;
        v.alu_assert_bus = sif.alu_assert_bus;
        v.halted         = sif.halted;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %06h expected %06h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_b(input string name, input logic ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL %s: got 0 expected 1 at %0t", name, $time);
        end
    endtask

    function automatic void push(input logic g, input logic d, input strobe_t o);
        step_t s;
        s.gate     = g;
        s.dispatch = d;
        s.o        = o;
        q.push_back(s);
    endfunction

    function automatic void push_fetch();
        strobe_t o;
        o = '0;
        o.mem_rd = 1'b1;
        push(1'b1, 1'b0, o);
        o.ir_load = 1'b1;
        o.pc_inc  = 1'b1;
        push(1'b0, 1'b1, o);
    endfunction

    // Instruction semantics: the cycles each opcode class must produce.
    function automatic void execute(input logic [7:0] op);
        strobe_t o;
        o = '0;
        case (op[7:6])
            2'b00: begin
                o.assert_bus = 4'b0001 << op[1:0];
                push(1'b0, 1'b0, o);
                o.load_bus = 4'b0001 << op[3:2];
                push(1'b0, 1'b0, o);
            end
            2'b01: begin
                o.assert_lhs = 4'b0001 << op[3:2];
                o.assert_rhs = 4'b0001 << op[1:0];
                o.alu_op     = op[5:4];
                push(1'b0, 1'b0, o);
                o.alu_latch = 1'b1;
                push(1'b0, 1'b0, o);
                o = '0;
                o.alu_assert_bus = 1'b1;
                push(1'b0, 1'b0, o);
                o.load_bus = 4'b0001 << op[3:2];
                push(1'b0, 1'b0, o);
            end
            2'b10: begin
                o.mem_rd = 1'b1;
                push(1'b1, 1'b0, o);
                o.pc_inc   = 1'b1;
                o.load_bus = 4'b0001 << op[1:0];
                push(1'b0, 1'b0, o);
            end
            default: begin
                if (op == 8'hFF) m_halt = 1'b1;
            end
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs seen at that edge.
    function automatic void model_step(input logic r, input logic mr, input logic rn,
                                       input logic [7:0] b);
        step_t h;
        if (!rn) begin
            q.delete();
            m_idle = 1'b1;
            m_halt = 1'b0;
        end else begin
            if (q.size() > 0) begin
                h = q[0];
                if (!(h.gate && !mr)) begin
                    void'(q.pop_front());
                    if (h.dispatch) execute(b);
                end
            end
            if (q.size() == 0 && !m_halt) begin
                if (!m_idle) begin
                    push_fetch();
                end else if (r) begin
                    m_idle = 1'b0;
                    push_fetch();
                end
            end
        end
        if (q.size() > 0) begin
            m_exp = q[0].o;
        end else begin
            m_exp = '0;
            m_exp.halted = m_halt;
        end
    endfunction

    // One clock: drive at negedge, update model at posedge, compare just after.
    task automatic cycle(input logic r, input logic mr, input logic rn);
        strobe_t    a;
        logic [5:0] drv;
        @(negedge clk);
        rst_n         = rn;
        sif.run       = r;
        sif.mem_ready = mr;
        sif.bus_in    = prog[pc];
        @(posedge clk);
        model_step(r, mr, rn, sif.bus_in);
        #1;
        a = dut_vec();
        chk("model", 32'(a), 32'(m_exp));
        drv = {a.mem_rd, a.alu_assert_bus, a.assert_bus};
        chk_b("one_driver", $countones(drv) <= 1);
        chk_b("onehot", $onehot0(a.assert_lhs) && $onehot0(a.assert_rhs) &&
                        $onehot0(a.assert_bus) && $onehot0(a.load_bus));
        if (a.load_bus != 4'b0000) chk_b("load_after_drive", drv != '0 && drv == prev_drv);
        prev_drv = drv;
        if (a.pc_inc) pc_inc_cnt++;
        // Memory-side PC advances on the edge that ends a pc_inc cycle.
        if (!rn) begin
            pc       = 0;
            inc_prev = 1'b0;
        end else begin
            if (inc_prev) pc = (pc + 1) % 64;
            inc_prev = a.pc_inc;
        end
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic pin(input string name, input strobe_t exp);
        chk(name, 32'(dut_vec()), 32'(exp));
    endtask

    initial begin
        rst_n         = 1'b0;
        sif.run       = 1'b0;
        sif.mem_ready = 1'b0;
        sif.bus_in    = 8'h00;
        m_idle        = 1'b1;
        m_halt        = 1'b0;
        m_exp         = '0;
        for (int i = 0; i < 64; i++) prog[i] = 8'hC3;
        prog[0] = 8'h06; prog[1] = 8'h5B; prog[2] = 8'h82; prog[3] = 8'h5A;
        prog[4] = 8'hC3; prog[5] = 8'hFF;

        // Directed program: MOV B,C; SUB C,D; LDI C; NOP; HALT.
        do_reset();
        e = '0;                                     pin("reset_zero", e);
        cycle(1'b1, 1'b1, 1'b1);
        e = '0; e.mem_rd = 1'b1;                    pin("mov_fd", e);
        cycle(1'b0, 1'b1, 1'b1);
        e.ir_load = 1'b1; e.pc_inc = 1'b1;          pin("mov_fl", e);
        cycle(1'b0, 1'b1, 1'b1);
        e = '0; e.assert_bus = 4'b0100;             pin("mov_md", e);
        cycle(1'b0, 1'b1, 1'b1);
        e.load_bus = 4'b0010;                       pin("mov_ml", e);
        cycle(1'b0, 1'b1, 1'b1);
        e = '0; e.mem_rd = 1'b1;                    pin("mov_back_fd", e);
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        e = '0; e.assert_lhs = 4'b0100; e.assert_rhs = 4'b1000; e.alu_op = 2'd1;
        pin("alu_ad", e);
        cycle(1'b0, 1'b1, 1'b1);
        e.alu_latch = 1'b1;                         pin("alu_al", e);
        cycle(1'b0, 1'b1, 1'b1);
        e = '0; e.alu_assert_bus = 1'b1;            pin("alu_wd", e);
        cycle(1'b0, 1'b1, 1'b1);
        e.load_bus = 4'b0100;                       pin("alu_wl", e);
        pc_inc_cnt = 0;
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);                    // mem_ready ignored leaving F_L
        e = '0; e.mem_rd = 1'b1;                    pin("ldi_id0", e);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b1);
            pin("ldi_id_wait", e);
        end
        cycle(1'b0, 1'b1, 1'b1);
        e.pc_inc = 1'b1; e.load_bus = 4'b0100;      pin("ldi_il", e);
        chk("ldi_pc_inc_count", 32'(pc_inc_cnt), 32'd2);
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        e = '0; e.mem_rd = 1'b1;                    pin("nop_back_fd", e);
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        e = '0; e.halted = 1'b1;                    pin("halt", e);
        for (int i = 0; i < 6; i++) begin
            cycle(1'(i % 2), 1'((i / 2) % 2), 1'b1);
            pin("halt_sticky", e);
        end

        // Reset in M_D abandons the transfer.
        do_reset();
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        e = '0; e.assert_bus = 4'b0100;             pin("rst_md", e);
        cycle(1'b0, 1'b1, 1'b0);
        e = '0;                                     pin("rst_mid_zero", e);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b1);
            pin("rst_idle_wait", e);
        end
        cycle(1'b1, 1'b1, 1'b1);
        e.mem_rd = 1'b1;                            pin("rst_rerun", e);

        // Randomised opcode streams with random stalls, run pulses and resets.
        for (int ep = 0; ep < 20; ep++) begin
            for (int k = 0; k < 64; k++) prog[k] = 8'($urandom_range(0, 255));
            if (ep % 3 == 0) prog[$urandom_range(8, 63)] = 8'hFF;
            do_reset();
            for (int c = 0; c < 200; c++) begin
                cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0),
                      1'($urandom_range(0, 99) != 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
